// File: rtl/wb_arbiter.sv
// Writeback scheduler: per-source result FIFOs feeding one registered writeback bus, round-robin grant.
// Optional statistics counters are built when WB_STATS_EN is defined.
`ifndef ROB_QUEUE_BITS
`define ROB_QUEUE_BITS 6
`endif

module wb_arbiter_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         nonempty,
    output logic         ready
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop)  rp <= rp + 1'b1;
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset; occupancy is tracked by cnt alone.
    always_ff @(posedge clk) begin
        if (push) mem[wp] <= din;
    end

    assign dout     = mem[rp];
    assign nonempty = (cnt != '0);
    assign ready    = (cnt < CW'(DEPTH));
endmodule

module wb_arbiter #(
    parameter int NUM_SRC    = 4,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                flush,
    input  logic [NUM_SRC-1:0]                  in_valid,
    input  logic [NUM_SRC*`ROB_QUEUE_BITS-1:0]  in_uid,
    input  logic [NUM_SRC*16-1:0]               in_val,
    input  logic [NUM_SRC*18-1:0]               in_loc,
    output logic [NUM_SRC-1:0]                  in_ready,
    output logic                                wb_valid,
    output logic [`ROB_QUEUE_BITS-1:0]          wb_uid,
    output logic [15:0]                         wb_val,
    output logic [17:0]                         wb_loc,
    output logic [$clog2(NUM_SRC)-1:0]          wb_src
`ifdef WB_STATS_EN
    ,
    output logic [31:0]                         stat_grants,
    output logic [31:0]                         stat_conflicts
`endif
);
    localparam int UW = `ROB_QUEUE_BITS;
    localparam int PW = UW + 34;
    localparam int SW = $clog2(NUM_SRC);

    logic [NUM_SRC-1:0][PW-1:0] head;
    logic [NUM_SRC-1:0]         nonempty;
    logic [NUM_SRC-1:0]         grant;
    logic [SW-1:0]              rr_ptr;
    logic [SW-1:0]              winner;
    logic                       found;

    genvar g;
    for (g = 0; g < NUM_SRC; g++) begin : g_src
        wb_arbiter_fifo #(.W(PW), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk      (clk),
            .rst      (rst),
            .clr      (flush),
            .push     (in_valid[g] && in_ready[g] && !flush),
            .pop      (grant[g]),
            .din      ({in_uid[g*UW +: UW], in_val[g*16 +: 16], in_loc[g*18 +: 18]}),
            .dout     (head[g]),
            .nonempty (nonempty[g]),
            .ready    (in_ready[g])
        );
    end

    // First non-empty source at or above rr_ptr, wrapping around.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!found && nonempty[(int'(rr_ptr) + k) % NUM_SRC]) begin
                found  = 1'b1;
                winner = SW'((int'(rr_ptr) + k) % NUM_SRC);
            end
        end
    end

    always_comb begin
        grant = '0;
        if (found && !flush) grant[winner] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid <= 1'b0;
            wb_uid   <= '0;
            wb_val   <= '0;
            wb_loc   <= '0;
            wb_src   <= '0;
            rr_ptr   <= '0;
        end else if (flush) begin
            wb_valid <= 1'b0;
            rr_ptr   <= '0;
        end else if (found) begin
            wb_valid                 <= 1'b1;
            {wb_uid, wb_val, wb_loc} <= head[winner];
            wb_src                   <= winner;
            rr_ptr                   <= (winner == SW'(NUM_SRC - 1)) ? '0 : winner + 1'b1;
        end else begin
            wb_valid <= 1'b0;
        end
    end

`ifdef WB_STATS_EN
    // Counters survive flush; only rst clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_grants    <= '0;
            stat_conflicts <= '0;
        end else if (!flush) begin
            if (found)                   stat_grants    <= stat_grants + 1'b1;
            if ($countones(nonempty) > 1) stat_conflicts <= stat_conflicts + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus random traffic against a queue-based model.
`ifndef ROB_QUEUE_BITS
`define ROB_QUEUE_BITS 6
`endif

module tb_wb_arbiter;
    localparam int N  = 4;
    localparam int D  = 2;
    localparam int UW = `ROB_QUEUE_BITS;
    localparam int SW = $clog2(N);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    logic [N-1:0]    in_valid = '0;
    logic [N*UW-1:0] in_uid = '0;
    logic [N*16-1:0] in_val = '0;
    logic [N*18-1:0] in_loc = '0;
    logic [N-1:0]    in_ready;
    logic            wb_valid;
    logic [UW-1:0]   wb_uid;
    logic [15:0]     wb_val;
    logic [17:0]     wb_loc;
    logic [SW-1:0]   wb_src;
`ifdef WB_STATS_EN
    logic [31:0]     stat_grants, stat_conflicts;
`endif

    always #5 clk = ~clk;

    wb_arbiter #(.NUM_SRC(N), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_uid(in_uid), .in_val(in_val), .in_loc(in_loc),
        .in_ready(in_ready),
        .wb_valid(wb_valid), .wb_uid(wb_uid), .wb_val(wb_val), .wb_loc(wb_loc), .wb_src(wb_src)
`ifdef WB_STATS_EN
        , .stat_grants(stat_grants), .stat_conflicts(stat_conflicts)
`endif
    );

    typedef struct packed {
        logic [UW-1:0] uid;
        logic [15:0]   val;
        logic [17:0]   loc;
    } item_t;

    item_t         q[N][$];
    int            rr = 0;
    logic          e_valid = 1'b0;
    logic [UW-1:0] e_uid = '0;
    logic [15:0]   e_val = '0;
    logic [17:0]   e_loc = '0;
    logic [SW-1:0] e_src = '0;
    logic [31:0]   e_grants = '0, e_conf = '0;
    logic [N-1:0]  last_acc = '0;
    int            cmp = 0;
    int            errs = 0;
    logic          saw_bp;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        cmp++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_src(input int i, input logic [UW-1:0] u, input logic [15:0] v, input logic [17:0] l);
        in_valid[i]          = 1'b1;
        in_uid[i*UW +: UW]   = u;
        in_val[i*16 +: 16]   = v;
        in_loc[i*18 +: 18]   = l;
    endtask

    // Sources present new data only once the previous offer was taken.
    task automatic drive(input logic [N-1:0] want);
        for (int i = 0; i < N; i++) begin
            if (want[i]) begin
                if (!in_valid[i] || last_acc[i])
                    set_src(i, UW'($urandom), 16'($urandom), 18'($urandom));
                else
                    in_valid[i] = 1'b1;
            end else begin
                in_valid[i] = 1'b0;
            end
        end
    endtask

    // One clock: predict the edge from queue contents, then compare after it.
    task automatic cycle();
        int    w;
        int    ne;
        item_t it;
        logic [N-1:0] acc;
        for (int i = 0; i < N; i++) chk("in_ready", 64'(in_ready[i]), 64'(q[i].size() < D));
        acc = '0;
        w   = -1;
        ne  = 0;
        for (int i = 0; i < N; i++) if (q[i].size() > 0) ne++;
        if (rst) begin
            for (int i = 0; i < N; i++) q[i].delete();
            rr = 0; e_valid = 1'b0; e_uid = '0; e_val = '0; e_loc = '0; e_src = '0;
            e_grants = '0; e_conf = '0;
        end else if (flush) begin
            for (int i = 0; i < N; i++) q[i].delete();
            rr = 0; e_valid = 1'b0;
        end else begin
            for (int k = 0; k < N; k++) if (w < 0 && q[(rr + k) % N].size() > 0) w = (rr + k) % N;
            for (int i = 0; i < N; i++) acc[i] = in_valid[i] && (q[i].size() < D);
            if (ne > 1) e_conf++;
            if (w >= 0) begin
                it = q[w].pop_front();
                e_valid = 1'b1; e_uid = it.uid; e_val = it.val; e_loc = it.loc;
                e_src = SW'(w); rr = (w + 1) % N; e_grants++;
            end else begin
                e_valid = 1'b0;
            end
            for (int i = 0; i < N; i++) if (acc[i]) begin
                it.uid = in_uid[i*UW +: UW];
                it.val = in_val[i*16 +: 16];
                it.loc = in_loc[i*18 +: 18];
                q[i].push_back(it);
            end
        end
        last_acc = acc;
        @(posedge clk);
        #1;
        chk("wb_valid", 64'(wb_valid), 64'(e_valid));
        chk("wb_uid", 64'(wb_uid), 64'(e_uid));
        chk("wb_val", 64'(wb_val), 64'(e_val));
        chk("wb_loc", 64'(wb_loc), 64'(e_loc));
        chk("wb_src", 64'(wb_src), 64'(e_src));
`ifdef WB_STATS_EN
        chk("stat_grants", 64'(stat_grants), 64'(e_grants));
        chk("stat_conflicts", 64'(stat_conflicts), 64'(e_conf));
`endif
    endtask

    task automatic idle(input int n);
        in_valid = '0;
        for (int t = 0; t < n; t++) cycle();
    endtask

    task automatic single_src_latency(input string tag);
        set_src(2, UW'(5), 16'hFF80, 18'h00007);
        cycle();
        in_valid = '0;
        cycle();
        chk({tag, "_valid"}, 64'(wb_valid), 64'(1));
        chk({tag, "_uid"}, 64'(wb_uid), 64'(5));
        chk({tag, "_val"}, 64'(wb_val), 64'hFF80);
        chk({tag, "_loc"}, 64'(wb_loc), 64'h00007);
        chk({tag, "_src"}, 64'(wb_src), 64'(2));
        cycle();
        chk({tag, "_pulse_end"}, 64'(wb_valid), 64'(0));
        chk({tag, "_ready"}, 64'(in_ready), 64'hF);
    endtask

    initial begin
        // First edge brings state out of X before the model takes over.
        @(posedge clk);
        #1;
        cycle();
        rst = 1'b0;

        single_src_latency("lat");

        // Round-robin burst from rr_ptr = 0.
        rst = 1'b1; cycle(); rst = 1'b0;
        for (int i = 0; i < N; i++) set_src(i, UW'(10 + i), 16'(16'h100 + i), 18'(18'h30000 + i));
        cycle();
        in_valid = '0;
        for (int k = 0; k < N; k++) begin
            cycle();
            chk("rr_src", 64'(wb_src), 64'(k));
        end
        set_src(1, UW'(21), 16'h1111, 18'h10001);
        set_src(3, UW'(23), 16'h3333, 18'h20003);
        cycle();
        in_valid = '0;
        cycle();
        chk("rr2_first", 64'(wb_src), 64'(1));
        cycle();
        chk("rr2_second", 64'(wb_src), 64'(3));
        idle(2);

        // Backpressure: source 0 competes with three saturating sources.
        saw_bp = 1'b0;
        for (int t = 0; t < 12; t++) begin
            drive({3'b111, (t < 6) || (in_valid[0] && !last_acc[0])});
            if (!in_ready[0]) saw_bp = 1'b1;
            cycle();
        end
        chk("bp_ready0_dropped", 64'(saw_bp), 64'(1));
        idle(12);

        // Flush with source 1 buffered and source 3 offering.
        set_src(1, UW'(31), 16'hAAAA, 18'h00031); cycle();
        set_src(1, UW'(32), 16'hBBBB, 18'h00032); cycle();
        in_valid = '0;
        set_src(3, UW'(33), 16'hCCCC, 18'h00033);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        in_valid = '0;
        chk("flush_wbv", 64'(wb_valid), 64'(0));
        chk("flush_ready", 64'(in_ready), 64'hF);
        idle(3);

        // Reset while a burst is draining.
        for (int i = 0; i < N; i++) set_src(i, UW'(40 + i), 16'(16'h4000 + i), 18'(18'h04000 + i));
        cycle();
        in_valid = '0;
        cycle();
        chk("rst_pre_valid", 64'(wb_valid), 64'(1));
        rst = 1'b1; cycle(); rst = 1'b0;
        chk("rst_wbv", 64'(wb_valid), 64'(0));
        chk("rst_uid", 64'(wb_uid), 64'(0));
        chk("rst_val", 64'(wb_val), 64'(0));
        chk("rst_loc", 64'(wb_loc), 64'(0));
        chk("rst_src", 64'(wb_src), 64'(0));
        single_src_latency("lat2");
        idle(2);

`ifdef WB_STATS_EN
        rst = 1'b1; cycle(); rst = 1'b0;
        for (int i = 0; i < N; i++) set_src(i, UW'(50 + i), 16'(i), 18'(i));
        cycle();
        idle(5);
        chk("stat_burst_grants", 64'(stat_grants), 64'(4));
        chk("stat_burst_conf", 64'(stat_conflicts), 64'(3));
        flush = 1'b1; cycle(); flush = 1'b0;
        chk("stat_flush_grants", 64'(stat_grants), 64'(4));
        chk("stat_flush_conf", 64'(stat_conflicts), 64'(3));
        rst = 1'b1; cycle(); rst = 1'b0;
        chk("stat_rst_grants", 64'(stat_grants), 64'(0));
        chk("stat_rst_conf", 64'(stat_conflicts), 64'(0));
`endif

        // Random traffic with occasional flush and reset.
        for (int t = 0; t < 400; t++) begin
            logic [N-1:0] want;
            flush = ($urandom_range(0, 99) < 3);
            rst   = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < N; i++)
                want[i] = (in_valid[i] && !last_acc[i]) || ($urandom_range(0, 99) < 40);
            drive(want);
            cycle();
        end
        rst = 1'b0;
        flush = 1'b0;
        idle(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end
endmodule
